// File: rtl/dcache_axi_rd_bridge.sv
// Dcache line-refill bridge: one outstanding request, mapped onto a single AXI4 INCR read burst.
// Optional response/rlast checking with a sticky rd_err is enabled by defining DCACHE_AXI_RD_CHECK_EN.
module dcache_axi_rd_bridge #(
  parameter int unsigned LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  input  logic        r_data_ready,
  output logic        r_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] r_data_AXI,
  output logic        rd_err,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_line_addr;
  logic [CW-1:0]   r_cnt;
  logic            w_ar_hs;
  logic            w_beat;
  logic            w_cnt_last;

  assign araddr     = r_line_addr;
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign r_data_AXI = rdata;

  assign w_ar_hs    = (r_state == ADDR) && arready;
  assign w_beat     = (r_state == DATA) && rvalid && r_data_ready;
  assign w_cnt_last = (r_cnt == CW'(LINE_WORDS - 1));

  always_comb begin
    w_next    = r_state;
    arvalid   = 1'b0;
    r_rdy     = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req) w_next = ADDR;
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          r_rdy  = 1'b1;
          w_next = DATA;
        end
      end
      DATA: begin
        rready    = r_data_ready;
        ret_valid = rvalid && r_data_ready;
        // End of line is decided by the beat count; rlast is only cross-checked.
        ret_last  = ret_valid && w_cnt_last;
        if (w_beat && w_cnt_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_line_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && r_req) r_line_addr <= {r_addr[31:6], 6'b0};
      if (w_ar_hs)     r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef DCACHE_AXI_RD_CHECK_EN
  logic r_rd_err;
  logic w_unused;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_err <= 1'b0;
    end else if (w_ar_hs) begin
      r_rd_err <= 1'b0;
    end else if (w_beat && ((rresp != 2'b00) || (rlast != w_cnt_last))) begin
      r_rd_err <= 1'b1;
    end
  end

  assign rd_err   = r_rd_err;
  assign w_unused = ^r_addr[5:0];
`else
  logic w_unused;

  assign rd_err   = 1'b0;
  assign w_unused = ^{r_addr[5:0], rresp, rlast};
`endif

endmodule
